// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge: bridges the core's level-held M-stage load/store request
// onto a single-outstanding req/ack memory bus and returns a one-cycle
// completion pulse (data_mem_ack_M) plus registered load data.
// Optional build macro: DMEM_POSTED_WRITE_EN enables a one-entry posted
// write buffer (stores ack immediately and drain on the bus in the background).
module dmem_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TMO_W          = 8,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write_M,
  input  logic        mem_or_alu_M,
  input  logic [3:0]  byte_repeat_en_M,
  input  logic [31:0] alu_out_M,
  input  logic [31:0] write_data_M,
  output logic [31:0] read_data_M,
  output logic        data_mem_ack_M,
  output logic        bus_err_M,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } state_e;

  // Last REQ cycle index (counter starts at 0 in the first bus_req cycle).
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q;
  logic [TMO_W-1:0] tmo_q;
  logic [31:0]      rdata_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;
  logic             req_q;
  logic             we_q;
  logic             ack_q;
  logic             err_q;

  logic             req;
  logic             is_store;
  logic             store_nop;
  logic             accept;
  logic             tmo_hit;
  logic             unused_addr_lsb;

  assign req       = mem_write_M | mem_or_alu_M;
  assign is_store  = mem_write_M;
  assign store_nop = is_store & (byte_repeat_en_M == 4'b0000);
  // Timeout fires only on a bus_req cycle without ack; a same-cycle ack wins.
  assign tmo_hit   = req_q & ~bus_ack & (tmo_q == TMO_LAST);

  // Byte offset is irrelevant on the bus: the word address is used and the
  // core supplies byte enables / performs load extraction itself.
  assign unused_addr_lsb = ^alu_out_M[1:0];

`ifdef DMEM_POSTED_WRITE_EN
  logic wb_busy_q;
  logic err_sticky_q;

  // Any new request (load or store) waits in IDLE while the buffer drains.
  assign accept    = req & ~wb_busy_q;
  assign bus_err_M = err_q | err_sticky_q;
`else
  assign accept    = req;
  assign bus_err_M = err_q;
`endif

  assign read_data_M    = rdata_q;
  assign data_mem_ack_M = ack_q;
  assign bus_req        = req_q;
  assign bus_we         = we_q;
  assign bus_addr       = addr_q;
  assign bus_be         = be_q;
  assign bus_wdata      = wdata_q;

  // Request FSM, bus-side registers and timeout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tmo_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef DMEM_POSTED_WRITE_EN
      wb_busy_q    <= 1'b0;
      err_sticky_q <= 1'b0;
`endif
    end else begin
      // Counts cycles of the current bus transaction; cleared otherwise.
      if (req_q && !bus_ack && !tmo_hit) begin
        tmo_q <= tmo_q + TMO_W'(1);
      end else begin
        tmo_q <= '0;
      end

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            we_q    <= is_store;
            addr_q  <= {alu_out_M[31:2], 2'b00};
            be_q    <= is_store ? byte_repeat_en_M : 4'b1111;
            wdata_q <= write_data_M;
            if (store_nop) begin
              ack_q   <= 1'b1;
              state_q <= ST_RESP;
            end
`ifdef DMEM_POSTED_WRITE_EN
            // The latched bus registers double as the write buffer entry.
            else if (is_store) begin
              req_q     <= 1'b1;
              wb_busy_q <= 1'b1;
              ack_q     <= 1'b1;
              state_q   <= ST_RESP;
            end
`endif
            else begin
              req_q   <= 1'b1;
              state_q <= ST_REQ;
            end
          end
        end

        ST_REQ: begin
          if (bus_ack || tmo_hit) begin
            req_q   <= 1'b0;
            ack_q   <= 1'b1;
            state_q <= ST_RESP;
            if (!bus_ack) begin
              err_q <= 1'b1;
            end
            if (!we_q) begin
              rdata_q <= bus_ack ? bus_rdata : ERR_RDATA;
            end
          end
        end

        ST_RESP: begin
          // Request still shows the finished op here, so it is not sampled.
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase

`ifdef DMEM_POSTED_WRITE_EN
      // Background drain of the posted write; never overlaps a load in REQ.
      if (wb_busy_q && (bus_ack || tmo_hit)) begin
        req_q     <= 1'b0;
        wb_busy_q <= 1'b0;
        if (!bus_ack) begin
          err_sticky_q <= 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Testbench for dmem_bus_bridge: fixed vector table, randomized ops against
// a transaction-level reference, and hand sequences for back-to-back loads,
// mid-transaction reset and (when built with DMEM_POSTED_WRITE_EN) posting.
module tb_dmem_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_write_M;
  logic        mem_or_alu_M;
  logic [3:0]  byte_repeat_en_M;
  logic [31:0] alu_out_M;
  logic [31:0] write_data_M;
  logic [31:0] read_data_M;
  logic        data_mem_ack_M;
  logic        bus_err_M;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack;

  int checks   = 0;
  int failures = 0;

  // Bus slave state
  int          ack_delay = 0;      // -1: never acknowledge
  logic        force_ack = 1'b0;
  logic        slv_ack   = 1'b0;
  int          req_cnt   = 0;
  int          starts    = 0;
  int          last_req_cycles = 0;
  logic [31:0] cap_addr  = '0;
  logic [31:0] cap_wdata = '0;
  logic [3:0]  cap_be    = '0;
  logic        cap_we    = 1'b0;
  logic [31:0] bus_mem [16];
  logic [31:0] ref_mem [16];

  assign bus_ack = slv_ack | force_ack;

  dmem_bus_bridge #(
    .TIMEOUT_CYCLES(255),
    .TMO_W         (8),
    .ERR_RDATA     (32'hDEAD_BEEF)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_write_M     (mem_write_M),
    .mem_or_alu_M    (mem_or_alu_M),
    .byte_repeat_en_M(byte_repeat_en_M),
    .alu_out_M       (alu_out_M),
    .write_data_M    (write_data_M),
    .read_data_M     (read_data_M),
    .data_mem_ack_M  (data_mem_ack_M),
    .bus_err_M       (bus_err_M),
    .bus_req         (bus_req),
    .bus_we          (bus_we),
    .bus_addr        (bus_addr),
    .bus_be          (bus_be),
    .bus_wdata       (bus_wdata),
    .bus_rdata       (bus_rdata),
    .bus_ack         (bus_ack)
  );

  always #5 clk = ~clk;

  // Memory-bus slave: acks after ack_delay cycles of bus_req, records txns.
  initial begin : slave
    forever begin
      @(posedge clk);
      #3;
      slv_ack = 1'b0;
      if (bus_req && !reset) begin
        if (req_cnt == 0) begin
          starts++;
          cap_addr  = bus_addr;
          cap_wdata = bus_wdata;
          cap_be    = bus_be;
          cap_we    = bus_we;
        end
        if (ack_delay >= 0 && req_cnt == ack_delay) begin
          slv_ack = 1'b1;
          if (cap_we) begin
            for (int b = 0; b < 4; b++) begin
              if (cap_be[b]) bus_mem[cap_addr[5:2]][8*b +: 8] = cap_wdata[8*b +: 8];
            end
          end else begin
            bus_rdata = bus_mem[cap_addr[5:2]];
          end
        end
        req_cnt++;
      end else begin
        if (req_cnt > 0) last_req_cycles = req_cnt;
        req_cnt = 0;
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Present one request, wait (bounded) for the ack pulse, then release.
  task automatic run_op(input logic w, input logic r, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd, input int dly,
                        output int lat, output logic err, output logic [31:0] rd);
    mem_write_M      = w;
    mem_or_alu_M     = r;
    alu_out_M        = a;
    byte_repeat_en_M = be;
    write_data_M     = wd;
    ack_delay        = dly;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (data_mem_ack_M !== 1'b1 && lat < 400);
    err = bus_err_M;
    rd  = read_data_M;
    tick();
    mem_write_M  = 1'b0;
    mem_or_alu_M = 1'b0;
    chk("ack_single_cycle", data_mem_ack_M, 1'b0);
    chk("err_single_cycle", bus_err_M, 1'b0);
  endtask

  typedef struct {
    string       name;
    logic        w;
    logic        r;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          dly;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_rd;
    int          exp_starts;
    logic [31:0] exp_baddr;
    logic [3:0]  exp_be;
    logic        exp_we;
    int          exp_reqcyc;
  } vec_t;

  vec_t vecs[8];

  initial begin : main
    int          lat;
    logic        err;
    logic [31:0] rd;
    int          s0;
    int          pulses;
    logic [31:0] v;

    reset            = 1'b1;
    mem_write_M      = 1'b0;
    mem_or_alu_M     = 1'b0;
    byte_repeat_en_M = '0;
    alu_out_M        = '0;
    write_data_M     = '0;
    for (int i = 0; i < 16; i++) begin
      bus_mem[i] = 32'h0101_0101 * i;
      ref_mem[i] = 32'h0101_0101 * i;
    end

    tick();
    tick();
    chk("rst_read_data", read_data_M, 32'h0);
    chk("rst_ack", data_mem_ack_M, 1'b0);
    chk("rst_err", bus_err_M, 1'b0);
    chk("rst_bus_req", bus_req, 1'b0);
    chk("rst_bus_we", bus_we, 1'b0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_be", bus_be, 4'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    reset = 1'b0;
    tick();

`ifndef DMEM_POSTED_WRITE_EN
    // ---------------- table-driven vectors ----------------
    bus_mem[1] = 32'h1234_5678;
    bus_mem[3] = 32'h5A5A_1234;
    vecs[0] = '{"load_1004", 1'b0, 1'b1, 32'h0000_1004, 4'h3, 32'h0, 3,
                5, 1'b0, 32'h1234_5678, 1, 32'h0000_1004, 4'hF, 1'b0, 4};
    vecs[1] = '{"store_2003", 1'b1, 1'b0, 32'h0000_2003, 4'h8, 32'hAB00_0000, 0,
                2, 1'b0, 32'h1234_5678, 1, 32'h0000_2000, 4'h8, 1'b1, 1};
    vecs[2] = '{"store_be0", 1'b1, 1'b0, 32'h0000_2008, 4'h0, 32'h1, 0,
                1, 1'b0, 32'h1234_5678, 0, 32'h0, 4'h0, 1'b0, 0};
    vecs[3] = '{"both_is_store", 1'b1, 1'b1, 32'h0000_1006, 4'h3, 32'h0000_CAFE, 1,
                3, 1'b0, 32'h1234_5678, 1, 32'h0000_1004, 4'h3, 1'b1, 2};
    vecs[4] = '{"load_merged", 1'b0, 1'b1, 32'h0000_1005, 4'h0, 32'h0, 0,
                2, 1'b0, 32'h1234_CAFE, 1, 32'h0000_1004, 4'hF, 1'b0, 1};
    vecs[5] = '{"load_timeout", 1'b0, 1'b1, 32'h0000_100C, 4'h0, 32'h0, -1,
                256, 1'b1, 32'hDEAD_BEEF, 1, 32'h0000_100C, 4'hF, 1'b0, 255};
    vecs[6] = '{"load_ack_at_limit", 1'b0, 1'b1, 32'h0000_100C, 4'h0, 32'h0, 254,
                256, 1'b0, 32'h5A5A_1234, 1, 32'h0000_100C, 4'hF, 1'b0, 255};
    vecs[7] = '{"store_timeout", 1'b1, 1'b0, 32'h0000_1010, 4'hF, 32'h9999_9999, -1,
                256, 1'b1, 32'h5A5A_1234, 1, 32'h0000_1010, 4'hF, 1'b1, 255};

    for (int i = 0; i < 8; i++) begin
      s0 = starts;
      run_op(vecs[i].w, vecs[i].r, vecs[i].addr, vecs[i].be, vecs[i].wd, vecs[i].dly,
             lat, err, rd);
      chk({vecs[i].name, "_latency"}, lat, vecs[i].exp_lat);
      chk({vecs[i].name, "_err"}, err, vecs[i].exp_err);
      chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
      chk({vecs[i].name, "_bus_txns"}, starts - s0, vecs[i].exp_starts);
      if (vecs[i].exp_starts > 0) begin
        chk({vecs[i].name, "_bus_addr"}, cap_addr, vecs[i].exp_baddr);
        chk({vecs[i].name, "_bus_be"}, cap_be, vecs[i].exp_be);
        chk({vecs[i].name, "_bus_we"}, cap_we, vecs[i].exp_we);
        chk({vecs[i].name, "_req_cycles"}, last_req_cycles, vecs[i].exp_reqcyc);
        if (vecs[i].exp_we) chk({vecs[i].name, "_bus_wdata"}, cap_wdata, vecs[i].wd);
      end
    end

    // ---------------- randomized ops vs reference ----------------
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      bus_mem[i] = v;
      ref_mem[i] = v;
    end
    begin
      logic [31:0] last_rd;
      last_rd = read_data_M;
      for (int n = 0; n < 60; n++) begin
        int unsigned kind;
        int unsigned idx;
        logic        w, r, st;
        logic [3:0]  be;
        logic [31:0] a, wd;
        int          dly, exp_lat, exp_st;
        logic        exp_err;
        kind = $urandom_range(0, 2);
        w  = (kind != 0);
        r  = (kind != 1);
        st = w;
        idx = $urandom_range(0, 15);
        a  = 32'h0000_4000 + idx * 4 + $urandom_range(0, 3);
        be = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        wd = $urandom;
        dly = (n == 20 || n == 45) ? -1 : int'($urandom_range(0, 4));
        exp_err = 1'b0;
        if (st && be == 4'h0) begin
          exp_lat = 1;
          exp_st  = 0;
        end else if (dly < 0) begin
          exp_lat = 256;
          exp_st  = 1;
          exp_err = 1'b1;
          if (!st) last_rd = 32'hDEAD_BEEF;
        end else begin
          exp_lat = dly + 2;
          exp_st  = 1;
          if (st) ref_mem[idx] = merge(ref_mem[idx], wd, be);
          else    last_rd = ref_mem[idx];
        end
        s0 = starts;
        run_op(w, r, a, be, wd, dly, lat, err, rd);
        chk("rnd_latency", lat, exp_lat);
        chk("rnd_err", err, exp_err);
        chk("rnd_rdata", rd, last_rd);
        chk("rnd_bus_txns", starts - s0, exp_st);
        if (exp_st > 0) begin
          chk("rnd_bus_addr", cap_addr, {a[31:2], 2'b00});
          chk("rnd_bus_we", cap_we, st);
          chk("rnd_bus_be", cap_be, st ? be : 4'hF);
          if (st) chk("rnd_bus_wdata", cap_wdata, wd);
        end
      end
    end
`endif

    // ---------------- back-to-back loads held continuously ----------------
    ack_delay    = 0;
    mem_or_alu_M = 1'b1;
    mem_write_M  = 1'b0;
    alu_out_M    = 32'h0000_4004;
    s0     = starts;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (data_mem_ack_M === 1'b1) pulses++;
    end
    mem_or_alu_M = 1'b0;
    tick();
    tick();
    tick();
    chk("b2b_ack_pulses", pulses, 4);
    chk("b2b_bus_txns", starts - s0, 4);
    chk("b2b_rdata", read_data_M, ref_mem[1]);

    // ---------------- reset while in REQ ----------------
    ack_delay    = -1;
    mem_or_alu_M = 1'b1;
    alu_out_M    = 32'h0000_4010;
    tick();
    tick();
    tick();
    chk("pre_reset_bus_req", bus_req, 1'b1);
    reset        = 1'b1;
    mem_or_alu_M = 1'b0;
    tick();
    chk("reset_drops_bus_req", bus_req, 1'b0);
    chk("reset_no_ack", data_mem_ack_M, 1'b0);
    chk("reset_read_data", read_data_M, 32'h0);
    reset     = 1'b0;
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (data_mem_ack_M === 1'b1 || bus_req === 1'b1) pulses++;
    end
    chk("stray_ack_ignored", pulses, 0);

`ifdef DMEM_POSTED_WRITE_EN
    // ---------------- posted store then load ----------------
    s0 = starts;
    run_op(1'b1, 1'b0, 32'h0000_4008, 4'hF, 32'h7777_0001, 3, lat, err, rd);
    chk("posted_store_latency", lat, 1);
    chk("posted_store_err", err, 1'b0);
    run_op(1'b0, 1'b1, 32'h0000_4008, 4'h0, 32'h0, 0, lat, err, rd);
    chk("posted_load_waits_latency", lat, 5);
    chk("posted_load_rdata", rd, 32'h7777_0001);
    chk("posted_bus_txns", starts - s0, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
